// File: rtl/zeroriscy_trace_buffer.sv
// Instruction trace capture for zero-riscy: retire and LSU writeback records into a circular buffer.
// Optional macro TRACE_PC_FILTER_EN adds a PC window filter (filt_lo/filt_hi) on retire records.
module zeroriscy_trace_buffer #(
    parameter int DEPTH          = 16,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CYC_WIDTH      = 16,
    parameter int CNT_W          = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      wrap_mode,
    input  logic [31:0]               trig_pc,
    input  logic [CNT_W-1:0]          post_trig,
`ifdef TRACE_PC_FILTER_EN
    input  logic [31:0]               filt_lo,
    input  logic [31:0]               filt_hi,
`endif
    input  logic                      retire_valid,
    input  logic [31:0]               retire_pc,
    input  logic [31:0]               retire_instr,
    input  logic [REG_ADDR_WIDTH-1:0] retire_rd,
    input  logic [31:0]               retire_rd_wdata,
    input  logic                      retire_mem_en,
    input  logic [31:0]               retire_mem_addr,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [31:0]               wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_type,
    output logic [CYC_WIDTH-1:0]      out_cycle,
    output logic [31:0]               out_pc,
    output logic [31:0]               out_instr,
    output logic [REG_ADDR_WIDTH-1:0] out_reg_addr,
    output logic [31:0]               out_reg_data,
    output logic                      out_mem_en,
    output logic [31:0]               out_mem_addr,
    output logic [1:0]                state,
    output logic [CNT_W-1:0]          count,
    output logic                      overflow,
    output logic [7:0]                drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIG  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                      typ;
        logic [CYC_WIDTH-1:0]      cyc;
        logic [31:0]               pc;
        logic [31:0]               instr;
        logic [REG_ADDR_WIDTH-1:0] reg_addr;
        logic [31:0]               reg_data;
        logic                      mem_en;
        logic [31:0]               mem_addr;
    } rec_t;

    state_t                    state_q, state_d;
    rec_t                      mem [DEPTH];
    rec_t                      head_q, head_d, rec;
    logic [PTR_W-1:0]          rd_ptr_q, wr_ptr_q, rd_nxt, wr_nxt;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          since_q, since_d, post_q;
    logic [CYC_WIDTH-1:0]      cyc_q;
    logic                      ovf_q, wrap_q;
    logic [31:0]               trig_q;
    logic [7:0]                drop_q;
    logic                      skid_full_q, skid_full_d;
    logic [REG_ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
    logic [31:0]               skid_data_q, skid_data_d;
    logic                      pass, ret_sel, wb_sel, capture, have_rec, drop;
    logic                      pop, full, push, overwrite, refuse, hit;

`ifdef TRACE_PC_FILTER_EN
    logic [31:0] filt_lo_q, filt_hi_q;
    assign pass = (retire_pc >= filt_lo_q) && (retire_pc <= filt_hi_q);
`else
    assign pass = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        since_d     = since_q;
        skid_full_d = skid_full_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        rec         = '0;
        rec.cyc     = cyc_q;
        have_rec    = 1'b0;
        drop        = 1'b0;
        capture     = (state_q == ST_ARMED) || (state_q == ST_TRIG);
        ret_sel     = retire_valid && pass;
        wb_sel      = wb_valid && (wb_addr != '0);

        // Retire wins the write port; a parked writeback drains on the next retire-free cycle.
        if (capture) begin
            if (ret_sel) begin
                have_rec      = 1'b1;
                rec.pc        = retire_pc;
                rec.instr     = retire_instr;
                rec.reg_addr  = retire_rd;
                rec.reg_data  = retire_rd_wdata;
                rec.mem_en    = retire_mem_en;
                rec.mem_addr  = retire_mem_addr;
                if (wb_sel) begin
                    if (skid_full_q) begin
                        drop = 1'b1;
                    end else begin
                        skid_full_d = 1'b1;
                        skid_addr_d = wb_addr;
                        skid_data_d = wb_data;
                    end
                end
            end else if (skid_full_q) begin
                have_rec     = 1'b1;
                rec.typ      = 1'b1;
                rec.reg_addr = skid_addr_q;
                rec.reg_data = skid_data_q;
                skid_full_d  = 1'b0;
                drop         = wb_sel;
            end else if (wb_sel) begin
                have_rec     = 1'b1;
                rec.typ      = 1'b1;
                rec.reg_addr = wb_addr;
                rec.reg_data = wb_data;
            end
        end

        pop       = (count_q != '0) && out_ready;
        full      = (count_q == CNT_W'(DEPTH));
        push      = have_rec && (!full || wrap_q || pop);
        overwrite = have_rec && full && wrap_q && !pop;
        refuse    = have_rec && full && !wrap_q && !pop;
        hit       = retire_valid && (retire_pc == trig_q);

        case (state_q)
            ST_ARMED: begin
                if (hit) begin
                    if (push && ret_sel && (post_q == ONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_TRIG;
                        since_d = (push && ret_sel) ? ONE : '0;
                    end
                end
            end
            ST_TRIG: begin
                if (push) begin
                    if (since_q + ONE == post_q) state_d = ST_DONE;
                    else                         since_d = since_q + ONE;
                end
            end
            default: ;
        endcase
        if (state_d == ST_DONE) skid_full_d = 1'b0;

        rd_nxt  = rd_ptr_q + PTR_W'(pop || overwrite);
        wr_nxt  = wr_ptr_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push && !overwrite) - CNT_W'(pop);

        // Head register mirrors the next oldest entry, bypassing a record landing in that slot.
        head_d = head_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_nxt)) head_d = rec;
            else                              head_d = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !arm && push) mem[wr_ptr_q] <= rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            since_q     <= '0;
            post_q      <= ONE;
            cyc_q       <= '0;
            ovf_q       <= 1'b0;
            wrap_q      <= 1'b0;
            trig_q      <= '0;
            drop_q      <= '0;
            skid_full_q <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
`ifdef TRACE_PC_FILTER_EN
            filt_lo_q   <= '0;
            filt_hi_q   <= '0;
`endif
        end else begin
            cyc_q <= cyc_q + CYC_WIDTH'(1);
            if (arm) begin
                state_q     <= ST_ARMED;
                rd_ptr_q    <= '0;
                wr_ptr_q    <= '0;
                count_q     <= '0;
                since_q     <= '0;
                post_q      <= (post_trig == '0) ? ONE : post_trig;
                ovf_q       <= 1'b0;
                wrap_q      <= wrap_mode;
                trig_q      <= trig_pc;
                drop_q      <= '0;
                skid_full_q <= 1'b0;
`ifdef TRACE_PC_FILTER_EN
                filt_lo_q   <= filt_lo;
                filt_hi_q   <= filt_hi;
`endif
            end else begin
                state_q     <= state_d;
                head_q      <= head_d;
                rd_ptr_q    <= rd_nxt;
                wr_ptr_q    <= wr_nxt;
                count_q     <= count_d;
                since_q     <= since_d;
                skid_full_q <= skid_full_d;
                skid_addr_q <= skid_addr_d;
                skid_data_q <= skid_data_d;
                if (overwrite || refuse) ovf_q <= 1'b1;
                if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_type     = head_q.typ;
    assign out_cycle    = head_q.cyc;
    assign out_pc       = head_q.pc;
    assign out_instr    = head_q.instr;
    assign out_reg_addr = head_q.reg_addr;
    assign out_reg_data = head_q.reg_data;
    assign out_mem_en   = head_q.mem_en;
    assign out_mem_addr = head_q.mem_addr;
    assign state        = state_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_zeroriscy_trace_buffer.sv
// Bench for zeroriscy_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_zeroriscy_trace_buffer;

    localparam int DEPTH = 4;
    localparam int RW    = 5;
    localparam int CW    = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, arm, wrap_mode, out_ready;
    logic [31:0]      trig_pc;
    logic [CNT_W-1:0] post_trig;
    logic             retire_valid, retire_mem_en, wb_valid;
    logic [31:0]      retire_pc, retire_instr, retire_rd_wdata, retire_mem_addr, wb_data;
    logic [RW-1:0]    retire_rd, wb_addr;
`ifdef TRACE_PC_FILTER_EN
    logic [31:0]      filt_lo = 32'h0;
    logic [31:0]      filt_hi = 32'hFFFF_FFFF;
`endif
    logic             out_valid, out_type, out_mem_en, overflow;
    logic [CW-1:0]    out_cycle;
    logic [31:0]      out_pc, out_instr, out_reg_data, out_mem_addr;
    logic [RW-1:0]    out_reg_addr;
    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [7:0]       drop_cnt;

    zeroriscy_trace_buffer #(.DEPTH(DEPTH), .REG_ADDR_WIDTH(RW), .CYC_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .wrap_mode(wrap_mode), .trig_pc(trig_pc),
        .post_trig(post_trig),
`ifdef TRACE_PC_FILTER_EN
        .filt_lo(filt_lo), .filt_hi(filt_hi),
`endif
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .retire_rd(retire_rd), .retire_rd_wdata(retire_rd_wdata), .retire_mem_en(retire_mem_en),
        .retire_mem_addr(retire_mem_addr), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type), .out_cycle(out_cycle),
        .out_pc(out_pc), .out_instr(out_instr), .out_reg_addr(out_reg_addr),
        .out_reg_data(out_reg_data), .out_mem_en(out_mem_en), .out_mem_addr(out_mem_addr),
        .state(state), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic          typ;
        logic [CW-1:0] cyc;
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [RW-1:0] ra;
        logic [31:0]   rdat;
        logic          men;
        logic [31:0]   maddr;
    } rec_t;

    typedef struct packed {
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic [7:0]       drop;
    } stat_t;

    rec_t  exp_q[$];
    stat_t stat_q[$];
    rec_t  mbuf[$];
    int    total = 0;
    int    bad = 0;

    // Reference model state (states numbered as on the state output).
    int            m_state, m_cyc, m_drop, m_post, m_since;
    bit            m_skid_full, m_ovf, m_wrap;
    logic [RW-1:0] m_skid_a;
    logic [31:0]   m_skid_d, m_trig;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic model_step();
        rec_t  r;
        stat_t s;
        bit    have, pop, full, written;
        int    stamp;
        if (rst) begin
            mbuf.delete();
            m_state = 0; m_cyc = 0; m_drop = 0; m_since = 0;
            m_skid_full = 0; m_ovf = 0;
        end else begin
            stamp = m_cyc;
            m_cyc = (m_cyc + 1) % (1 << CW);
            pop = (mbuf.size() > 0) && out_ready;
            if (pop) exp_q.push_back(mbuf[0]);
            if (arm) begin
                mbuf.delete();
                m_state = 1; m_skid_full = 0; m_ovf = 0; m_drop = 0; m_since = 0;
                m_wrap = wrap_mode; m_trig = trig_pc;
                m_post = (post_trig == 0) ? 1 : int'(post_trig);
            end else begin
                full = (mbuf.size() == DEPTH);
                if (pop) void'(mbuf.pop_front());
                have = 0;
                r = '0;
                r.cyc = CW'(stamp);
                if (m_state == 1 || m_state == 2) begin
                    if (retire_valid) begin
                        have = 1;
                        r.pc = retire_pc; r.instr = retire_instr; r.ra = retire_rd;
                        r.rdat = retire_rd_wdata; r.men = retire_mem_en; r.maddr = retire_mem_addr;
                        if (wb_valid && wb_addr != 0) begin
                            if (m_skid_full) m_drop++;
                            else begin m_skid_full = 1; m_skid_a = wb_addr; m_skid_d = wb_data; end
                        end
                    end else if (m_skid_full) begin
                        have = 1; r.typ = 1; r.ra = m_skid_a; r.rdat = m_skid_d;
                        m_skid_full = 0;
                        if (wb_valid && wb_addr != 0) m_drop++;
                    end else if (wb_valid && wb_addr != 0) begin
                        have = 1; r.typ = 1; r.ra = wb_addr; r.rdat = wb_data;
                    end
                end
                written = 0;
                if (have) begin
                    if (!full || pop) written = 1;
                    else if (m_wrap) begin void'(mbuf.pop_front()); m_ovf = 1; written = 1; end
                    else m_ovf = 1;
                    if (written) mbuf.push_back(r);
                end
                if (m_state == 1 && retire_valid && retire_pc == m_trig) begin
                    m_since = written ? 1 : 0;
                    m_state = (m_since >= m_post) ? 3 : 2;
                end else if (m_state == 2 && written) begin
                    m_since++;
                    if (m_since >= m_post) m_state = 3;
                end
                if (m_state == 3) m_skid_full = 0;
            end
        end
        s.st = 2'(m_state);
        s.cnt = CNT_W'(mbuf.size());
        s.ovf = m_ovf;
        s.drop = (m_drop > 255) ? 8'hFF : 8'(m_drop);
        stat_q.push_back(s);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        rst = 0; arm = 0; retire_valid = 0; wb_valid = 0;
    endtask

    task automatic do_arm(input bit w, input logic [31:0] tp, input int pt);
        arm = 1; wrap_mode = w; trig_pc = tp; post_trig = CNT_W'(pt);
        step();
    endtask

    task automatic set_retire(input logic [31:0] pc, input logic [RW-1:0] rd);
        retire_valid = 1; retire_pc = pc; retire_instr = $urandom; retire_rd = rd;
        retire_rd_wdata = $urandom; retire_mem_en = 1'($urandom_range(0, 1));
        retire_mem_addr = $urandom;
    endtask

    task automatic set_wb(input logic [RW-1:0] a, input logic [31:0] d);
        wb_valid = 1; wb_addr = a; wb_data = d;
    endtask

    task automatic drain(input int n);
        out_ready = 1;
        repeat (n) step();
        out_ready = 0;
    endtask

    // Status monitor: DUT status after each edge against the model's prediction for that edge.
    stat_t s_mon;
    initial forever begin
        @(posedge clk);
        #2;
        if (stat_q.size() > 0) begin
            s_mon = stat_q.pop_front();
            total++;
            if ({state, count, overflow, drop_cnt} !== s_mon) begin
                bad++;
                $display("FAIL status: got st=%0d cnt=%0d ovf=%0d drop=%0d expected st=%0d cnt=%0d ovf=%0d drop=%0d",
                         state, count, overflow, drop_cnt, s_mon.st, s_mon.cnt, s_mon.ovf, s_mon.drop);
            end
        end
    end

    // Record monitor: every accepted head record is checked against the expected stream.
    rec_t e_mon, g_mon;
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            total++;
            g_mon.typ = out_type; g_mon.cyc = out_cycle; g_mon.pc = out_pc; g_mon.instr = out_instr;
            g_mon.ra = out_reg_addr; g_mon.rdat = out_reg_data; g_mon.men = out_mem_en;
            g_mon.maddr = out_mem_addr;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL record: got unexpected record %0h, expected none", g_mon);
            end else begin
                e_mon = exp_q.pop_front();
                if (g_mon !== e_mon) begin
                    bad++;
                    $display("FAIL record: got %0h expected %0h", g_mon, e_mon);
                end
            end
        end
    end

    initial begin
        rst = 1; arm = 0; wrap_mode = 0; out_ready = 0; trig_pc = 0; post_trig = 0;
        retire_valid = 0; retire_pc = 0; retire_instr = 0; retire_rd = 0; retire_rd_wdata = 0;
        retire_mem_en = 0; retire_mem_addr = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
        repeat (3) begin rst = 1; step(); end
        check("reset_state", 64'(state), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_pc", 64'(out_pc), 64'd0);
        check("reset_out_cycle", 64'(out_cycle), 64'd0);
        check("reset_drop", 64'(drop_cnt), 64'd0);
        step();

        // Stop mode with trigger at 0x80, three records from the trigger on.
        do_arm(0, 32'h80, 3);
        for (int i = 0; i < 5; i++) begin
            set_retire(32'h7C + 32'(4 * i), RW'(i + 1));
            step();
            if (i == 3) check("t1_done_after_88", 64'(state), 64'd3);
        end
        check("t1_count", 64'(count), 64'd4);
        check("t1_overflow", 64'(overflow), 64'd0);
        drain(6);

        // Wrap mode, no trigger hit: oldest two of six records are overwritten.
        do_arm(1, 32'hFFFF_FFF0, 3);
        for (int i = 0; i < 6; i++) begin
            set_retire(32'(4 * i), RW'(i));
            step();
        end
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_count", 64'(count), 64'd4);
        drain(6);
        check("t2_count_drained", 64'(count), 64'd0);

        // Retire with writeback in the same cycle: writeback drains from the skid a cycle later.
        do_arm(0, 32'hFFFF_FFF0, 3);
        set_retire(32'h200, 5'd0);
        set_wb(5'd5, 32'hDEAD_BEEF);
        step();
        step();
        check("t3_count", 64'(count), 64'd2);
        drain(4);

        // Second writeback while the skid is occupied is dropped.
        do_arm(0, 32'hFFFF_FFF0, 3);
        set_retire(32'h300, 5'd1); set_wb(5'd5, 32'h1111_1111); step();
        set_retire(32'h304, 5'd2); set_wb(5'd6, 32'h2222_2222); step();
        step();
        check("t4_drop_cnt", 64'(drop_cnt), 64'd1);
        check("t4_count", 64'(count), 64'd3);
        drain(5);

        // Stop mode full with a pop and push in the same cycle.
        do_arm(0, 32'hFFFF_FFF0, 3);
        for (int i = 0; i < 4; i++) begin set_retire(32'h400 + 32'(4 * i), 5'd3); step(); end
        set_retire(32'h410, 5'd4);
        out_ready = 1;
        step();
        out_ready = 0;
        check("t5_count", 64'(count), 64'd4);
        check("t5_overflow", 64'(overflow), 64'd0);
        drain(6);

        // Reset in the middle of a triggered capture.
        do_arm(0, 32'h100, 7);
        for (int i = 0; i < 3; i++) begin set_retire(32'h100 + 32'(4 * i), 5'd7); step(); end
        check("t6_state_trig", 64'(state), 64'd2);
        check("t6_count", 64'(count), 64'd3);
        rst = 1;
        step();
        check("t6_rst_state", 64'(state), 64'd0);
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_drop", 64'(drop_cnt), 64'd0);
        check("t6_rst_out_pc", 64'(out_pc), 64'd0);

        // Random traffic with periodic re-arming and rare resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) rst = 1;
            else if (n == 0 || $urandom_range(0, 59) == 0) begin
                arm = 1;
                wrap_mode = 1'($urandom_range(0, 1));
                trig_pc = 32'($urandom_range(0, 15)) << 2;
                post_trig = CNT_W'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 99) < 55)
                set_retire(32'($urandom_range(0, 15)) << 2, RW'($urandom_range(0, 31)));
            if ($urandom_range(0, 99) < 35) set_wb(RW'($urandom_range(0, 31)), $urandom);
            out_ready = ($urandom_range(0, 99) < 40);
            step();
        end
        drain(10);
        step();
        @(posedge clk);
        #3;
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
